bfloat_mac_acc: RTL
===================

// Module: bfloat_mac_acc
// PURPOSE
// - Accumulation stage of the bfloat16 MAC: consumes a stream of bfloat16 products
//   and folds each into a running sum through one bfloat_add_sub instance (cntl tied 0).
// - Emits one bfloat16 sum per burst on a valid/ready output.
// - Sits directly downstream of the multiplier stage and upstream of result write-back.
// PARAMETERS
// - MAX_TERMS  default 256  terms per burst before a forced close; must be >= 1
// - CNT_W      default 9    width of the term counter / out_count; must hold MAX_TERMS
// PORTS
// - clk        in   1   rising-edge clock
// - rst_n      in   1   asynchronous active-low reset
// - in_valid   in   1   product term present on in_data
// - in_ready   out  1   stage can accept a term this cycle
// - in_data    in   16  bfloat16 product term {sign, exp[7:0], mant[6:0]}
// - in_last    in   1   qualifies in_data as the final term of the burst
// - clear      in   1   synchronous abort: discard the burst and zero the sum
// - out_valid  out  1   burst sum available
// - out_ready  in   1   consumer takes out_data this cycle
// - out_data   out  16  bfloat16 burst sum
// - out_count  out  CNT_W  number of terms folded into out_data
// - out_forced out  1   burst was closed by MAX_TERMS and not by in_last
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, acc=16'h0000, cnt=0, in_ready=0,
//   out_valid=0, out_data=16'h0000, out_count=0, out_forced=0.
// - States:
//   - IDLE: in_ready=1. An accepted term moves the state to ACCUM, or to DONE if it closes the burst.
//   - ACCUM: in_ready=1.
//   - DONE: in_ready=0, out_valid=1.
// - Accept condition: accept = in_valid & in_ready & ~clear.
// - On accept:
//   - acc <= add(acc, in_data), the combinational adder result, in the same cycle.
//   - cnt <= cnt+1.
//   - Throughput is 1 term/cycle.
// - Burst close:
//   - The burst closes when the accepted term has in_last=1, or when cnt+1 == MAX_TERMS.
//   - On close: state <= DONE; out_data <= add result; out_count <= cnt+1.
//   - out_forced <= ~in_last.
//   - out_valid rises the cycle after the closing accept (latency 1).
// - DONE:
//   - out_data, out_count and out_forced are held stable while out_ready=0.
//   - On out_valid & out_ready: state <= IDLE, acc <= 0, cnt <= 0, out_valid <= 0.
//   - No term is accepted in that same cycle; in_ready rises the following cycle.
// - First term: acc=0, so the sum equals in_data exactly (0 + b = b).
// - Special values pass through the adder unchanged:
//   - The NaN pattern 16'hFFFF and +/-Inf (exp=8'hFF, mant=0) propagate into acc.
//   - Later terms are still accepted and counted.
// - clear:
//   - Has priority over accept and over the output handshake in the same cycle.
//   - Next state is IDLE, with acc=0, cnt=0, out_valid=0 and out_forced=0.
//   - out_data and out_count keep their last values.
// - in_last with in_valid=0 is ignored. in_data is don't-care when in_valid=0.
// - Reset mid-burst discards the partial sum. No output is produced for that burst.
// CONFIGURATION
// - BFLOAT_ACC_SAT_EN:
//   - Defined: the value loaded into out_data at close saturates.
//     +Inf becomes 16'h7F7F and -Inf becomes 16'hFF7F. NaN 16'hFFFF is unchanged.
//     acc itself is not altered.
//   - Undefined: out_data is exactly the adder result.
// TESTING
// - Reset: assert rst_n=0 mid-burst.
//   -> All outputs take their reset values immediately.
//   -> After release, the next burst of {3F80 last} gives out_data=3F80, out_count=1.
// - Sum of three: terms 3F80, 3F80, 3F80 (last) on consecutive cycles.
//   -> in_ready stays 1. out_valid rises 1 cycle after term 3.
//   -> out_data=4040 (3.0), out_count=3, out_forced=0.
// - Backpressure: out_ready=0 for 5 cycles after the sum of three.
//   -> out_valid=1, out_data=4040 and in_ready=0 are stable for all 5 cycles.
//   -> Raising out_ready gives out_valid=0 and in_ready=1 the next cycle.
// - Forced close: MAX_TERMS=4, terms 4000 x4 with in_last=0.
//   -> out_data=4100 (8.0), out_count=4, out_forced=1.
// - Clear: terms 3F80, 4000, then clear=1 asserted together with in_valid=1 and in_last=1.
//   -> The term is not accepted and out_valid stays 0.
//   -> The next burst {4040 last} gives out_data=4040.
// - Infinity: terms 7F80, 3F80 (last).
//   -> out_data=7F80 without BFLOAT_ACC_SAT_EN, 7F7F with it. out_count=2.

Source files
------------

// File: rtl/bfloat_mac_acc_if.sv
// Handshake bundle for the bfloat16 MAC accumulation stage.
// master drives terms and takes sums; slave is the stage.
interface bfloat_mac_acc_if #(
  parameter int CNT_W = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_last;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_forced;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output clear,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_count,
    input  out_forced
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  clear,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_count,
    output out_forced
  );
endinterface

// File: rtl/bfloat_mac_acc.sv
// bfloat16 burst accumulator: folds product terms into one sum per burst.
// Optional macro BFLOAT_ACC_SAT_EN saturates +/-Inf in the emitted sum.
module bfloat_add_sub (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cntl,
  output logic [15:0] o_sum
);
  logic        w_bs;
  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_a_inf;
  logic        w_b_inf;
  logic        w_swap;
  logic        w_ls;
  logic        w_ss;
  logic        w_sub;
  logic [14:0] w_lx;
  logic [14:0] w_sx;
  logic [9:0]  w_le;
  logic [9:0]  w_se;
  logic [9:0]  w_diff;
  logic [7:0]  w_lsig;
  logic [7:0]  w_ssig;
  logic [31:0] w_ext;
  logic [17:0] w_x;
  logic [17:0] w_y;
  logic [17:0] w_r;
  logic [4:0]  w_p;
  logic [9:0]  w_lz;
  logic [9:0]  w_sh;
  logic [16:0] w_t;
  logic [15:0] w_nm;
  logic        w_nst;
  logic [9:0]  w_e;
  logic        w_ru;
  logic [8:0]  w_s9;
  logic [7:0]  w_sig;
  logic [15:0] w_res;

  // Align, add/subtract, normalise and round to nearest even.
  always_comb begin
    w_bs    = i_b[15] ^ i_cntl;
    w_a_nan = (&i_a[14:7]) & (|i_a[6:0]);
    w_b_nan = (&i_b[14:7]) & (|i_b[6:0]);
    w_a_inf = (&i_a[14:7]) & ~(|i_a[6:0]);
    w_b_inf = (&i_b[14:7]) & ~(|i_b[6:0]);
    w_swap  = i_b[14:0] > i_a[14:0];
    w_ls    = w_swap ? w_bs : i_a[15];
    w_ss    = w_swap ? i_a[15] : w_bs;
    w_lx    = w_swap ? i_b[14:0] : i_a[14:0];
    w_sx    = w_swap ? i_a[14:0] : i_b[14:0];
    w_le    = (w_lx[14:7] == 8'h00) ? 10'd1
                                    : {2'b00, w_lx[14:7]};
    w_se    = (w_sx[14:7] == 8'h00) ? 10'd1
                                    : {2'b00, w_sx[14:7]};
    w_lsig  = {|w_lx[14:7], w_lx[6:0]};
    w_ssig  = {|w_sx[14:7], w_sx[6:0]};
    w_diff  = w_le - w_se;
    if (w_diff > 10'd16) begin
      w_ext = '0;
    end else begin
      w_ext = {w_ssig, 24'h0} >> w_diff[4:0];
    end
    w_x   = {1'b0, w_lsig, 8'h00, 1'b0};
    w_y   = {1'b0, w_ext[31:16], |w_ext[15:0]};
    w_sub = w_ls ^ w_ss;
    w_r   = w_sub ? (w_x - w_y) : (w_x + w_y);
    w_p   = '0;
    for (int i = 0; i < 17; i++) begin
      if (w_r[i]) w_p = 5'(i);
    end
    w_lz = 10'd16 - {5'b0, w_p};
    w_sh = (w_lz > (w_le - 10'd1)) ? (w_le - 10'd1) : w_lz;
    w_t  = '0;
    if (w_r[17]) begin
      w_nm  = w_r[17:2];
      w_nst = |w_r[1:0];
      w_e   = w_le + 10'd1;
    end else begin
      w_t   = w_r[16:0] << w_sh[4:0];
      w_nm  = w_t[16:1];
      w_nst = w_t[0];
      w_e   = w_le - w_sh;
    end
    w_ru = w_nm[7] & ((|w_nm[6:0]) | w_nst | w_nm[8]);
    w_s9 = {1'b0, w_nm[15:8]} + {8'h00, w_ru};
    if (w_s9[8]) begin
      w_sig = w_s9[8:1];
      w_e   = w_e + 10'd1;
    end else begin
      w_sig = w_s9[7:0];
    end
    if (w_r == 18'h0) begin
      w_res = {w_ls & ~w_sub, 15'h0};
    end else if (w_e >= 10'd255) begin
      w_res = {w_ls, 8'hFF, 7'h00};
    end else begin
      w_res = {w_ls, w_sig[7] ? w_e[7:0] : 8'h00, w_sig[6:0]};
    end
    if (w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (i_a[15] ^ w_bs))) begin
      o_sum = 16'hFFFF;
    end else if (w_a_inf) begin
      o_sum = {i_a[15], 8'hFF, 7'h00};
    end else if (w_b_inf) begin
      o_sum = {w_bs, 8'hFF, 7'h00};
    end else begin
      o_sum = w_res;
    end
  end
endmodule

module bfloat_mac_acc #(
  parameter int MAX_TERMS = 256,
  parameter int CNT_W     = 9
) (
  input logic              clk,
  input logic              rst_n,
  bfloat_mac_acc_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [15:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [15:0]      r_out_data;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_forced;

  logic [15:0]      w_sum;
  logic [15:0]      w_out_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_accept;
  logic             w_close;

  bfloat_add_sub u_add (
    .i_a    (r_acc),
    .i_b    (bus.in_data),
    .i_cntl (1'b0),
    .o_sum  (w_sum)
  );

  assign w_accept  = bus.in_valid & r_in_ready & ~bus.clear;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_close   = w_accept &
                     (bus.in_last | (w_cnt_inc == CNT_W'(MAX_TERMS)));

`ifdef BFLOAT_ACC_SAT_EN
  assign w_out_nxt = (w_sum[14:0] == 15'h7F80) ? {w_sum[15], 15'h7F7F}
                                               : w_sum;
`else
  assign w_out_nxt = w_sum;
`endif

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_count  = r_out_count;
  assign bus.out_forced = r_out_forced;

  // Burst FSM: accumulate terms, close the burst, hold the sum until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_count  <= '0;
      r_out_forced <= 1'b0;
    end else if (bus.clear) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_forced <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_ACCUM: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_inc;
            if (w_close) begin
              r_state      <= S_DONE;
              r_in_ready   <= 1'b0;
              r_out_valid  <= 1'b1;
              r_out_data   <= w_out_nxt;
              r_out_count  <= w_cnt_inc;
              r_out_forced <= ~bus.in_last;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
